// File: rtl/exec_stage_pkg.sv
// Shared constants for the execute stage: ALU operation codes and the
// control value that marks a pipeline bubble.
package exec_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  // {REG_WRITE, MEM_WRITE, MEM_TO_REG} all clear: nothing downstream may write
  localparam logic [2:0] CTRL_BUBBLE = 3'b000;

endpackage

// File: rtl/exec_stage_alu.sv
// Combinational ALU for the execute stage. Unknown operation codes
// fall back to addition, and results wrap modulo 2^XLEN.
module alu
  import exec_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = a + b;
    case (alu_op_e'(alu_control))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = a + b;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ID/EX register, MEM/WB operand forwarding, ALU, and the
// EX/MEM register that drives all outputs. Stall and flush insert bubbles.
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [2:0]      alu_control,
  input  logic            alu_src,
  input  logic [2:0]      ctrl_in,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            mem_fwd_en,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_en,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ctrl_out,
  output logic            zero
);

  typedef struct packed {
    logic            valid;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [2:0]      ctrl;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic [2:0]      ctrl;
    logic            zero;
  } ex_mem_t;

  id_ex_t          id_ex_d, id_ex_q;
  ex_mem_t         ex_mem_d, ex_mem_q;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_out;
  logic            alu_zero;

  // Flush beats stall on the ID/EX side; an invalid decode slot is a bubble too.
  always_comb begin
    id_ex_d      = '0;
    id_ex_d.ctrl = CTRL_BUBBLE;
    if (flush) begin
      id_ex_d      = '0;
      id_ex_d.ctrl = CTRL_BUBBLE;
    end else if (stall) begin
      id_ex_d = id_ex_q;
    end else if (id_valid) begin
      id_ex_d.valid       = 1'b1;
      id_ex_d.alu_control = alu_control;
      id_ex_d.alu_src     = alu_src;
      id_ex_d.ctrl        = ctrl_in;
      id_ex_d.rs1_addr    = rs1_addr;
      id_ex_d.rs2_addr    = rs2_addr;
      id_ex_d.rd          = rd_addr;
      id_ex_d.rs1_data    = rs1_data;
      id_ex_d.rs2_data    = rs2_data;
      id_ex_d.imm         = imm;
    end
  end

  // The MEM stage holds the younger result, so it takes priority over WB; x0 never forwards.
  always_comb begin
    fwd_a = id_ex_q.rs1_data;
    if (mem_fwd_en && (mem_fwd_rd == id_ex_q.rs1_addr) && (id_ex_q.rs1_addr != 5'd0))
      fwd_a = mem_fwd_data;
    else if (wb_fwd_en && (wb_fwd_rd == id_ex_q.rs1_addr) && (id_ex_q.rs1_addr != 5'd0))
      fwd_a = wb_fwd_data;

    fwd_b = id_ex_q.rs2_data;
    if (mem_fwd_en && (mem_fwd_rd == id_ex_q.rs2_addr) && (id_ex_q.rs2_addr != 5'd0))
      fwd_b = mem_fwd_data;
    else if (wb_fwd_en && (wb_fwd_rd == id_ex_q.rs2_addr) && (id_ex_q.rs2_addr != 5'd0))
      fwd_b = wb_fwd_data;

    op_b = id_ex_q.alu_src ? id_ex_q.imm : fwd_b;
  end

  alu #(.XLEN(XLEN)) u_alu (
    .alu_control (id_ex_q.alu_control),
    .a           (fwd_a),
    .b           (op_b),
    .result      (alu_out),
    .zero        (alu_zero)
  );

  always_comb begin
    ex_mem_d      = '0;
    ex_mem_d.ctrl = CTRL_BUBBLE;
    ex_mem_d.zero = 1'b1;
    if (!stall && id_ex_q.valid) begin
      ex_mem_d.valid      = 1'b1;
      ex_mem_d.alu_result = alu_out;
      ex_mem_d.store_data = fwd_b;
      ex_mem_d.rd         = id_ex_q.rd;
      ex_mem_d.ctrl       = id_ex_q.ctrl;
      ex_mem_d.zero       = alu_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q       <= '0;
      ex_mem_q      <= '0;
      ex_mem_q.zero <= 1'b1;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ex_valid   = ex_mem_q.valid;
  assign alu_result = ex_mem_q.alu_result;
  assign store_data = ex_mem_q.store_data;
  assign ex_rd      = ex_mem_q.rd;
  assign ctrl_out   = ex_mem_q.ctrl;
  assign zero       = ex_mem_q.zero;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed instructions push their
// hand-computed results; a negedge monitor pops and compares valid outputs.
module tb_exec_stage;
  import exec_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [2:0]  alu_control = 3'd0;
  logic        alu_src = 1'b0;
  logic [2:0]  ctrl_in = 3'd0;
  logic [4:0]  rs1_addr = 5'd0, rs2_addr = 5'd0, rd_addr = 5'd0;
  logic [31:0] rs1_data = 32'd0, rs2_data = 32'd0, imm = 32'd0;
  logic        mem_fwd_en = 1'b0, wb_fwd_en = 1'b0;
  logic [4:0]  mem_fwd_rd = 5'd0, wb_fwd_rd = 5'd0;
  logic [31:0] mem_fwd_data = 32'd0, wb_fwd_data = 32'd0;
  logic        ex_valid, zero;
  logic [31:0] alu_result, store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ctrl_out;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] store;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
  } exp_t;
  exp_t sb[$];

  exec_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .alu_control(alu_control), .alu_src(alu_src), .ctrl_in(ctrl_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .alu_result(alu_result), .store_data(store_data),
    .ex_rd(ex_rd), .ctrl_out(ctrl_out), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input logic [31:0] store,
                          input logic [4:0] rd, input logic [2:0] ctrl);
    exp_t e;
    e.res = res; e.store = store; e.rd = rd; e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  task automatic set_dec(input logic v, input logic [2:0] op, input logic src,
                         input logic [2:0] ctrl, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rd, input logic [31:0] da, input logic [31:0] db,
                         input logic [31:0] im);
    id_valid = v; alu_control = op; alu_src = src; ctrl_in = ctrl;
    rs1_addr = ra; rs2_addr = rb; rd_addr = rd;
    rs1_data = da; rs2_data = db; imm = im;
  endtask

  task automatic set_fwd(input logic men, input logic [4:0] mrd, input logic [31:0] mdat,
                         input logic wen, input logic [4:0] wrd, input logic [31:0] wdat);
    mem_fwd_en = men; mem_fwd_rd = mrd; mem_fwd_data = mdat;
    wb_fwd_en = wen; wb_fwd_rd = wrd; wb_fwd_data = wdat;
  endtask

  task automatic idle();
    set_dec(1'b0, 3'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic step(input logic st, input logic fl);
    stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    check({tag, "_result"}, alu_result, 32'd0);
    check({tag, "_store"}, store_data, 32'd0);
    check({tag, "_rd"}, {27'd0, ex_rd}, 32'd0);
    check({tag, "_ctrl"}, {29'd0, ctrl_out}, 32'd0);
    check({tag, "_zero"}, {31'd0, zero}, 32'd1);
  endtask

  // Monitor: every valid output must match the oldest expected entry; bubbles must be harmless.
  always @(negedge clk) begin
    if (!rst) begin
      if (ex_valid) begin
        if (sb.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_valid: got result %h rd %0d, expected no instruction",
                   alu_result, ex_rd);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("alu_result", alu_result, e.res);
          check("store_data", store_data, e.store);
          check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
          check("ctrl_out", {29'd0, ctrl_out}, {29'd0, e.ctrl});
          check("zero", {31'd0, zero}, {31'd0, (e.res == 32'd0)});
        end
      end else begin
        check("bubble_ctrl", {29'd0, ctrl_out}, 32'd0);
        check("bubble_rd", {27'd0, ex_rd}, 32'd0);
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1 check_reset_values("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic ALU operations, streamed back to back
    push_exp(32'd12, 32'd7, 5'd3, 3'b100);
    set_dec(1'b1, ALU_ADD, 1'b0, 3'b100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    step(1'b0, 1'b0);
    push_exp(32'hFFFF_FFFE, 32'd5, 5'd4, 3'b100);
    set_dec(1'b1, ALU_SUB, 1'b0, 3'b100, 5'd1, 5'd2, 5'd4, 32'd3, 32'd5, 32'd0);
    step(1'b0, 1'b0);
    push_exp(32'd0, 32'd9, 5'd5, 3'b100);
    set_dec(1'b1, ALU_SUB, 1'b0, 3'b100, 5'd1, 5'd2, 5'd5, 32'd9, 32'd9, 32'd0);
    step(1'b0, 1'b0);
    push_exp(32'h0000_F000, 32'h0000_FF00, 5'd6, 3'b101);
    set_dec(1'b1, ALU_AND, 1'b0, 3'b101, 5'd1, 5'd2, 5'd6, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    step(1'b0, 1'b0);
    push_exp(32'h0000_FFF0, 32'h0000_0F00, 5'd7, 3'b100);
    set_dec(1'b1, ALU_OR, 1'b0, 3'b100, 5'd1, 5'd2, 5'd7, 32'h0000_F0F0, 32'h0000_0F00, 32'd0);
    step(1'b0, 1'b0);
    push_exp(32'h0000_00F0, 32'h0000_000F, 5'd8, 3'b100);
    set_dec(1'b1, ALU_XOR, 1'b0, 3'b100, 5'd1, 5'd2, 5'd8, 32'h0000_00FF, 32'h0000_000F, 32'd0);
    step(1'b0, 1'b0);
    push_exp(32'd5, 32'd3, 5'd9, 3'b100);
    set_dec(1'b1, 3'b111, 1'b0, 3'b100, 5'd1, 5'd2, 5'd9, 32'd2, 32'd3, 32'd0);
    step(1'b0, 1'b0);
    push_exp(32'd9, 32'h55, 5'd0, 3'b010);
    set_dec(1'b1, ALU_ADD, 1'b1, 3'b010, 5'd1, 5'd2, 5'd0, 32'd10, 32'h55, 32'hFFFF_FFFF);
    step(1'b0, 1'b0);
    idle(); step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Forwarding: MEM beats WB, x0 never forwards, WB-only on rs2
    push_exp(32'h11, 32'd0, 5'd7, 3'b100);
    set_dec(1'b1, ALU_ADD, 1'b1, 3'b100, 5'd3, 5'd0, 5'd7, 32'hAAAA, 32'd0, 32'd1);
    step(1'b0, 1'b0);
    set_fwd(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
    push_exp(32'd1, 32'd0, 5'd7, 3'b100);
    set_dec(1'b1, ALU_ADD, 1'b1, 3'b100, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd1);
    step(1'b0, 1'b0);
    set_fwd(1'b1, 5'd0, 32'h10, 1'b1, 5'd0, 32'h20);
    push_exp(32'h101, 32'h100, 5'd12, 3'b100);
    set_dec(1'b1, ALU_ADD, 1'b0, 3'b100, 5'd1, 5'd9, 5'd12, 32'd1, 32'd1, 32'd0);
    step(1'b0, 1'b0);
    set_fwd(1'b1, 5'd8, 32'h999, 1'b1, 5'd9, 32'h100);
    idle(); step(1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Two-cycle stall: X held, then emerges once, followed by Y
    push_exp(32'd3, 32'd2, 5'd8, 3'b100);
    set_dec(1'b1, ALU_ADD, 1'b0, 3'b100, 5'd1, 5'd2, 5'd8, 32'd1, 32'd2, 32'd0);
    step(1'b0, 1'b0);
    set_dec(1'b1, ALU_XOR, 1'b0, 3'b100, 5'd1, 5'd2, 5'd9, 32'hF, 32'h3, 32'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    push_exp(32'hC, 32'h3, 5'd9, 3'b100);
    step(1'b0, 1'b0);
    idle(); step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Stall and flush together: Z is lost
    set_dec(1'b1, ALU_ADD, 1'b0, 3'b100, 5'd1, 5'd2, 5'd10, 32'd7, 32'd7, 32'd0);
    step(1'b0, 1'b0);
    idle(); step(1'b1, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Flush alone: F proceeds, W in decode is discarded
    push_exp(32'd3, 32'd2, 5'd11, 3'b001);
    set_dec(1'b1, ALU_OR, 1'b0, 3'b001, 5'd1, 5'd2, 5'd11, 32'd1, 32'd2, 32'd0);
    step(1'b0, 1'b0);
    set_dec(1'b1, ALU_ADD, 1'b0, 3'b100, 5'd1, 5'd2, 5'd12, 32'd100, 32'd1, 32'd0);
    step(1'b0, 1'b1);
    idle(); step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Reset with P in EX/MEM and Q in ID/EX: neither may appear
    set_dec(1'b1, ALU_ADD, 1'b0, 3'b100, 5'd1, 5'd2, 5'd13, 32'd40, 32'd2, 32'd0);
    step(1'b0, 1'b0);
    set_dec(1'b1, ALU_ADD, 1'b0, 3'b100, 5'd1, 5'd2, 5'd14, 32'd50, 32'd3, 32'd0);
    step(1'b0, 1'b0);
    rst = 1'b1;
    idle();
    #1 check_reset_values("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    push_exp(32'd6, 32'd4, 5'd15, 3'b100);
    set_dec(1'b1, ALU_ADD, 1'b0, 3'b100, 5'd1, 5'd2, 5'd15, 32'd2, 32'd4, 32'd0);
    step(1'b0, 1'b0);
    idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("queue_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
